// File: rtl/q3_resp_chk.sv
// Response checker for the q3 truth-table sweep: captures observed
// samples, compares them to a latched expected table, reports results.
module q3_resp_chk #(
   parameter int N_IN = 4,
   localparam int TT_W = 1 << N_IN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TT_W-1:0]   exp_tt,
   input  logic              in_valid,
   input  logic [N_IN-1:0]   in_idx,
   input  logic              in_f,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_cnt,
   output logic              first_err_vld,
   output logic [N_IN-1:0]   first_err_idx,
   output logic              seq_err,
   output logic [TT_W-1:0]   tt_obs
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CAP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [TT_W-1:0]   r_exp;
   logic [TT_W-1:0]   r_tt;
   logic [N_IN:0]     r_err;
   logic              r_fv;
   logic [N_IN-1:0]   r_fi;
   logic              r_seq;
   logic              r_pass;
   logic [N_IN-1:0]   r_eidx;
   logic [N_IN:0]     r_cnt;

   logic              w_acc;
   logic              w_mis;
   logic              w_last;
   logic              w_sat;
   logic [N_IN:0]     w_err_nxt;
   logic              w_seq_nxt;

   // start in the same cycle as a sample aborts and drops that sample
   assign w_acc  = in_valid && (r_state == S_CAP) && !start;
   assign w_mis  = in_f != r_exp[in_idx];
   assign w_last = r_cnt == (N_IN+1)'(TT_W - 1);
   assign w_sat  = &r_err;

   always_comb begin
      w_err_nxt = r_err;
      if (w_mis && !w_sat)
         w_err_nxt = r_err + (N_IN+1)'(1);
   end

   assign w_seq_nxt = r_seq || (in_idx != r_eidx);

   always_comb begin
      w_next = r_state;
      if (start) begin
         w_next = S_CAP;
      end else begin
         unique case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_CAP:   if (w_acc && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exp  <= '0;
         r_tt   <= '0;
         r_err  <= '0;
         r_fv   <= 1'b0;
         r_fi   <= '0;
         r_seq  <= 1'b0;
         r_pass <= 1'b0;
         r_eidx <= '0;
         r_cnt  <= '0;
      end else if (start) begin
         r_exp  <= exp_tt;
         r_tt   <= '0;
         r_err  <= '0;
         r_fv   <= 1'b0;
         r_fi   <= '0;
         r_seq  <= 1'b0;
         r_pass <= 1'b0;
         r_eidx <= '0;
         r_cnt  <= '0;
      end else if (w_acc) begin
         r_tt[in_idx] <= in_f;
         r_err        <= w_err_nxt;
         if (w_mis && !r_fv) begin
            r_fv <= 1'b1;
            r_fi <= in_idx;
         end
         r_seq  <= w_seq_nxt;
         r_eidx <= r_eidx + N_IN'(1);
         r_cnt  <= r_cnt + (N_IN+1)'(1);
         if (w_last)
            r_pass <= (w_err_nxt == '0) && !w_seq_nxt;
      end
   end

   assign in_ready      = r_state == S_CAP;
   assign busy          = r_state == S_CAP;
   assign done          = r_state == S_DONE;
   assign pass          = r_pass;
   assign err_cnt       = r_err;
   assign first_err_vld = r_fv;
   assign first_err_idx = r_fi;
   assign seq_err       = r_seq;
   assign tt_obs        = r_tt;

endmodule

// File: doc/q3_resp_chk.md
# q3_resp_chk

Hardware response checker for the q3 four-input logic function: the receiving end of the exhaustive stimulus sweep. It accepts one (pattern index, output bit) sample per handshake, assembles the observed truth table, compares each sample against an expected truth table latched at start, and reports pass/fail, error count and first failing index. It sits downstream of the q3 instance in self-checking benches and on-board test harnesses.

## Interface
Parameters:
- N_IN, default 4: number of function inputs. The truth table holds 2^N_IN bits (TT_W).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin or restart a sweep.
- exp_tt  in  TT_W  expected truth table. Bit i is the expected f for input pattern i, where i = {a,b,c,d}. Latched on start.
- in_valid  in  1  sample present.
- in_idx  in  N_IN  input pattern index of the sample.
- in_f  in  1  observed DUT output for in_idx.
- in_ready  out  1  checker accepts a sample this cycle.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held high until the next start or rst.
- pass  out  1  valid while done is high. 1 means zero mismatches and no sequence error.
- err_cnt  out  N_IN+1  number of mismatching samples.
- first_err_vld  out  1  at least one mismatch recorded.
- first_err_idx  out  N_IN  in_idx of the first mismatch.
- seq_err  out  1  sticky flag: an index arrived out of ascending order.
- tt_obs  out  TT_W  captured truth table.

## Operation
- Handshake: a sample is accepted on a clock edge when in_valid is high and in_ready is high. in_ready is a registered state decode: it is 1 only in CAPTURE.
- States:
  - IDLE: waiting. start moves to CAPTURE.
  - CAPTURE: accepting samples.
  - DONE: results held. start moves to CAPTURE.
- On start, in any state, on the same edge:
  - exp_reg takes exp_tt.
  - tt_obs, err_cnt, first_err_vld, first_err_idx and seq_err are cleared.
  - exp_idx and the accept count are cleared.
  - The state becomes CAPTURE.
  - start during CAPTURE aborts the current sweep. A sample presented in that same cycle is discarded.
- For each accepted sample:
  - tt_obs[in_idx] takes in_f.
  - If in_f differs from exp_reg[in_idx], err_cnt increments.
  - On the first such mismatch, first_err_idx takes in_idx and first_err_vld is set.
  - If in_idx differs from exp_idx, seq_err is set. It stays set until start or rst.
  - exp_idx and the accept count then increment.
- A duplicate index overwrites its tt_obs bit and is still counted and compared.
- err_cnt width N_IN+1 holds the maximum of 2^N_IN mismatches. It never wraps.
- exp_idx wraps modulo 2^N_IN. This is harmless because the sweep ends at 2^N_IN accepts.
- When the 2^N_IN-th sample is accepted, the state moves CAPTURE to DONE.
- pass = (err_cnt == 0) && !seq_err, registered so it is valid on entry to DONE.
- in_valid in IDLE or DONE is ignored and changes no state.
- exp_tt changes after start have no effect.

## Timing
- Reset values:
  - state IDLE.
  - in_ready, busy, done and pass 0.
  - err_cnt 0, first_err_vld 0, first_err_idx 0.
  - seq_err 0, tt_obs 0.
- Reset mid-sweep returns to IDLE immediately and discards everything.
- start at edge k: busy=1 and in_ready=1 from cycle k+1.
- Throughput is one sample per cycle. A full sweep takes at least 2^N_IN cycles.
- Last sample accepted at edge m: done=1, pass valid, busy=0 and in_ready=0 from cycle m+1.
- err_cnt, tt_obs and the flags update on the accepting edge and are visible the next cycle.
- start and in_valid high in the same CAPTURE cycle: start wins.

## Test plan
- Clean sweep: rst, start with exp_tt=16'hA5C3, then feed idx 0..15 with f=exp bit, one per cycle. Required: done at the cycle after the 16th accept, pass=1, err_cnt=0, tt_obs=16'hA5C3, first_err_vld=0.
- Two mismatches: same as the clean sweep but invert f at idx 5 and idx 12. Required: err_cnt=2, first_err_idx=5, first_err_vld=1, pass=0, tt_obs=16'hB5E3.
- Out-of-order sweep: feed idx 0,2,1,3..15 with correct f. Required: seq_err=1, err_cnt=0, pass=0, tt_obs matches exp_tt.
- Throttled input: toggle in_valid every other cycle. Required: in_ready stays 1 throughout CAPTURE, and results are identical to the clean sweep, with done 31 cycles after the first accept.
- Abort and reset:
  - Pulse start after 7 samples, then complete a clean sweep. Required: err_cnt, tt_obs and seq_err show only the second sweep, pass=1.
  - Assert rst mid-sweep. Required: state IDLE and all outputs at reset values on the next cycle.
- All-wrong sweep: exp_tt=16'h0000, feed f=1 for all 16 patterns. Required: err_cnt=16 (5'b10000, no wrap), first_err_idx=0, pass=0.
